// File: rtl/mem_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, address strides and
// the post-load state selection.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RUN,
        DUMP_RD,
        DUMP_WAIT,
        DUMP_OUT,
        DONE
    } state_e;

    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

    // Phase that follows program load (or a start with nothing to load).
    function automatic state_e after_load(input logic run_nz, input logic dump_nz);
        if (run_nz) begin
            return RUN;
        end else if (dump_nz) begin
            return DUMP_RD;
        end
        return DONE;
    endfunction

endpackage

// File: rtl/mem_loader_down_counter.sv
// Saturating down counter with synchronous load; zero_o flags an empty count.
module down_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_loader.sv
// Loads a program into instruction memory from a stream, runs the CPU for a
// fixed number of cycles, then streams data memory contents out.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 512,
    parameter int unsigned DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [9:0]  prog_len,
    input  logic [31:0] run_cycles,
    input  logic [10:0] dump_len,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done
);

    localparam logic [9:0]  IMEM_MAX = 10'(IMEM_DEPTH);
    localparam logic [10:0] DMEM_MAX = 11'(DMEM_DEPTH);

    state_e      state_q, state_d;
    logic [9:0]  plen_q, plen_d, widx_q, widx_d;
    logic [10:0] dlen_q, dlen_d, didx_q, didx_d;
    logic [31:0] run_q, run_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] mdata_q, mdata_d;
    logic [63:0] addr_q, addr2_q;
    logic        s_ready_q, wen_q, ren2_q, m_valid_q, cpu_q, busy_q, done_q;
    logic        cnt_load, cnt_zero;
    logic        unused_rdata;

    assign unused_rdata = ^rdata_ext;

    always_comb begin
        state_d  = state_q;
        plen_d   = plen_q;
        run_d    = run_q;
        dlen_d   = dlen_q;
        widx_d   = widx_q;
        didx_d   = didx_q;
        wdata_d  = wdata_q;
        mdata_d  = mdata_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    plen_d = (32'(prog_len) > IMEM_DEPTH) ? IMEM_MAX : prog_len;
                    run_d  = run_cycles;
                    dlen_d = (32'(dump_len) > DMEM_DEPTH) ? DMEM_MAX : dump_len;
                    widx_d = '0;
                    didx_d = '0;
                    state_d = (plen_d != '0) ? LOAD
                                             : after_load(run_d != '0, dlen_d != '0);
                end
            end
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    wdata_d = s_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                widx_d  = widx_q + 10'd1;
                state_d = (widx_d < plen_q) ? LOAD
                                            : after_load(run_q != '0, dlen_q != '0);
            end
            RUN: begin
                if (cnt_zero) begin
                    state_d = (dlen_q != '0) ? DUMP_RD : DONE;
                end
            end
            DUMP_RD: state_d = DUMP_WAIT;
            DUMP_WAIT: begin
                mdata_d = rdata_ext_2;
                state_d = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (m_ready && m_valid_q) begin
                    didx_d  = didx_q + 11'd1;
                    state_d = (didx_d < dlen_q) ? DUMP_RD : DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Preloading run-1 lets the counter reach zero on the last enabled cycle,
    // so a full 32-bit run length needs no extra counter bit.
    assign cnt_load = (state_d == RUN) && (state_q != RUN);

    down_counter #(.WIDTH(32)) u_run_cnt (
        .clk_i      (clk),
        .rst_ni     (arst_n),
        .load_i     (cnt_load),
        .load_val_i (run_d - 32'd1),
        .en_i       (state_q == RUN),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            plen_q    <= '0;
            run_q     <= '0;
            dlen_q    <= '0;
            widx_q    <= '0;
            didx_q    <= '0;
            wdata_q   <= '0;
            mdata_q   <= '0;
            addr_q    <= '0;
            addr2_q   <= '0;
            s_ready_q <= 1'b0;
            wen_q     <= 1'b0;
            ren2_q    <= 1'b0;
            m_valid_q <= 1'b0;
            cpu_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            plen_q    <= plen_d;
            run_q     <= run_d;
            dlen_q    <= dlen_d;
            widx_q    <= widx_d;
            didx_q    <= didx_d;
            wdata_q   <= wdata_d;
            mdata_q   <= mdata_d;
            // Addresses only move when used, keeping them inside the memories.
            if (state_d == WRITE) begin
                addr_q <= 64'(widx_d) * 64'(IMEM_STRIDE);
            end
            if (state_d == DUMP_RD) begin
                addr2_q <= 64'(didx_d) * 64'(DMEM_STRIDE);
            end
            s_ready_q <= (state_d == LOAD);
            wen_q     <= (state_d == WRITE);
            ren2_q    <= (state_d == DUMP_RD);
            m_valid_q <= (state_d == DUMP_OUT);
            cpu_q     <= (state_d == RUN);
            busy_q    <= (state_d != IDLE) && (state_d != DONE);
            done_q    <= (state_d == DONE);
        end
    end

    assign s_ready     = s_ready_q;
    assign addr_ext    = addr_q;
    assign wen_ext     = wen_q;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_q;
    assign addr_ext_2  = addr2_q;
    assign wen_ext_2   = 1'b0;
    assign ren_ext_2   = ren2_q;
    assign wdata_ext_2 = '0;
    assign m_valid     = m_valid_q;
    assign m_data      = mdata_q;
    assign cpu_enable  = cpu_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with write/dump scoreboards and a data-memory model.
module tb_mem_loader;

    localparam int unsigned IMEM_DEPTH = 512;
    localparam int unsigned DMEM_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        arst_n, start, s_valid, s_ready, m_ready, m_valid;
    logic [9:0]  prog_len;
    logic [31:0] run_cycles, s_data, wdata_ext;
    logic [31:0] rdata_ext = '0;
    logic [10:0] dump_len;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, m_data;
    logic [63:0] rdata_ext_2 = '0;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, done;

    always #5 clk = ~clk;

    mem_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .prog_len(prog_len),
        .run_cycles(run_cycles), .dump_len(dump_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cpu_enable(cpu_enable), .busy(busy), .done(done)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [63:0] dq[$];
    logic [63:0] dmem [DMEM_DEPTH];
    int          vectors = 0, errors = 0;
    int          wr_cnt = 0, dump_cnt = 0, cpu_cnt = 0, cyc = 0;
    int          cpu_first = -1, cpu_last = -1;
    logic [63:0] last_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Data memory: one-cycle read latency.
    always @(posedge clk) begin
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    always @(negedge clk) begin
        cyc++;
        if (wen_ext) begin
            wr_t e;
            check("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check("wr_addr", addr_ext, e.addr);
                check("wr_data", 64'(wdata_ext), 64'(e.data));
            end
            check("ren_ext_zero", 64'(ren_ext), 64'd0);
            wr_cnt++;
            last_addr = addr_ext;
        end
        if (ren_ext_2) check("wen_ext_2_zero", 64'(wen_ext_2) | wdata_ext_2, 64'd0);
        if (m_valid && m_ready) begin
            check("dump_expected", 64'(dq.size() != 0), 64'd1);
            if (dq.size() != 0) check("dump_data", m_data, dq.pop_front());
            dump_cnt++;
        end
        if (cpu_enable) begin
            check("cpu_excl", 64'(wen_ext | ren_ext_2), 64'd0);
            cpu_cnt++;
            if (cpu_first < 0) cpu_first = cyc;
            cpu_last = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [9:0] p, input logic [31:0] r, input logic [10:0] d);
        prog_len   = p;
        run_cycles = r;
        dump_len   = d;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic hs;
        int   n;
        hs = 1'b0;
        n  = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = s_ready;
            tick();
            n++;
        end
        s_valid = 1'b0;
        check("s_handshake", 64'(hs), 64'd1);
        repeat (gap) tick();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        tick();
    endtask

    task automatic clear_counts();
        wr_cnt = 0; dump_cnt = 0; cpu_cnt = 0; cpu_first = -1; cpu_last = -1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = 64'hD000_0000_0000_0000 | 64'(i);
        dmem[0] = 64'hA;
        dmem[1] = 64'hB;
        arst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        prog_len = '0; run_cycles = '0; dump_len = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'({s_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                                m_valid, cpu_enable, busy, done}), 64'd0);
        check("rst_addr", addr_ext | addr_ext_2, 64'd0);
        check("rst_data", 64'(wdata_ext) | wdata_ext_2 | m_data, 64'd0);
        tick();
        arst_n = 1'b1;
        tick();

        // Three-word load with s_valid gaps
        clear_counts();
        wq.push_back('{64'd0, 32'h11});
        wq.push_back('{64'd4, 32'h22});
        wq.push_back('{64'd8, 32'h33});
        start_seq(10'd3, 32'd0, 11'd0);
        @(negedge clk);
        check("load_busy", 64'({busy, s_ready, done}), 64'b110);
        tick();
        send_word(32'h11, 2);
        send_word(32'h22, 1);
        send_word(32'h33, 0);
        wait_done("load3", 50);
        check("load3_writes", 64'(wr_cnt), 64'd3);
        check("load3_queue", 64'(wq.size()), 64'd0);

        // Run only
        clear_counts();
        start_seq(10'd0, 32'd5, 11'd0);
        wait_done("run5", 50);
        check("run5_cycles", 64'(cpu_cnt), 64'd5);
        check("run5_consec", 64'(cpu_last - cpu_first + 1), 64'd5);

        // Dump with back-pressure
        clear_counts();
        dq.push_back(64'hA);
        dq.push_back(64'hB);
        m_ready = 1'b0;
        start_seq(10'd0, 32'd0, 11'd2);
        n = 0;
        while (m_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dump_valid", 64'(m_valid), 64'd1);
        repeat (4) begin
            @(negedge clk);
            check("stall_data", m_data, 64'hA);
            check("stall_valid", 64'(m_valid), 64'd1);
        end
        tick();
        m_ready = 1'b1;
        wait_done("dump2", 50);
        check("dump2_count", 64'(dump_cnt), 64'd2);
        check("dump2_queue", 64'(dq.size()), 64'd0);

        // Full sequence: load, run, dump
        clear_counts();
        wq.push_back('{64'd0, 32'hCAFE_0001});
        dq.push_back(64'hA);
        start_seq(10'd1, 32'd2, 11'd1);
        send_word(32'hCAFE_0001, 0);
        wait_done("seq", 50);
        check("seq_counts", {16'(wr_cnt), 16'(cpu_cnt), 16'(dump_cnt), 16'(wq.size() + dq.size())},
              {16'd1, 16'd2, 16'd1, 16'd0});

        // Reset in the third RUN cycle of ten
        clear_counts();
        start_seq(10'd0, 32'd10, 11'd0);
        n = 0;
        while (cpu_enable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("run10_start", 64'(cpu_enable), 64'd1);
        tick();
        tick();
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_run_ctrl", 64'({cpu_enable, busy, done, m_valid, s_ready}), 64'd0);
        check("rst_run_cycles", 64'(cpu_cnt), 64'd3);
        tick();
        arst_n = 1'b1;
        tick();

        // Empty start goes straight to DONE
        start_seq(10'd0, 32'd0, 11'd0);
        @(negedge clk);
        check("empty_done", 64'({done, busy}), 64'b10);
        tick();

        // Oversized program clamps to IMEM_DEPTH; start while busy is ignored
        clear_counts();
        for (int i = 0; i < IMEM_DEPTH; i++) wq.push_back('{64'(4 * i), 32'h5A00_0000 + 32'(i)});
        start_seq(10'd600, 32'd0, 11'd0);
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            if (i == 100) start_seq(10'd1, 32'd7, 11'd1);
            send_word(32'h5A00_0000 + 32'(i), 0);
        end
        wait_done("big", 200);
        check("big_writes", 64'(wr_cnt), 64'(IMEM_DEPTH));
        check("big_last_addr", last_addr, 64'd2044);
        check("big_ignored_start", 64'(cpu_cnt + dump_cnt), 64'd0);
        check("big_queue", 64'(wq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
